wb_result_bus: RTL and testbench

Writeback-side collector for the four execution units (ALU, SFU, BRU, AGU). Captures each unit's tagged result into a small per-unit queue, arbitrates round-robin onto a single registered common result bus (CDB) consumed by the ROB and reservation stations, and raises a registered redirect when a resolved branch was mispredicted. Sits directly after the execution stage and is the only path from the execution units to architectural and speculative state.

---
 rtl/wb_result_bus_if.sv | 61 ++++++
 rtl/wb_result_bus.sv | 212 +++++++++++++++++++++
 tb/tb_wb_result_bus.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/wb_result_bus_if.sv
// Execution-unit result bus: per-unit result inputs with ready, plus the common
// result bus and branch redirect outputs. flush from commit control rides along.
interface wb_result_bus_if;
    logic        flush;

    logic        alu_en;
    logic [5:0]  alu_rd;
    logic [31:0] alu_out;
    logic        alu_ovf;
    logic        alu_ready;

    logic        sfu_en;
    logic [5:0]  sfu_rd;
    logic [31:0] sfu_out;
    logic        sfu_ready;

    logic        bru_en;
    logic [5:0]  bru_rd;
    logic [31:0] bru_addr;
    logic        bru_pre_right;
    logic        bru_b_type;
    logic        bru_real_dir;
    logic        bru_ready;

    logic        agu_en;
    logic [5:0]  agu_rd;
    logic [31:0] agu_out;
    logic        agu_ready;

    logic        cdb_valid;
    logic [5:0]  cdb_tag;
    logic [31:0] cdb_data;
    logic [1:0]  cdb_src;
    logic        cdb_exc;
    logic        cdb_b_type;
    logic        cdb_real_dir;
    logic        redirect_valid;
    logic [31:0] redirect_addr;

    modport master (
        output flush,
        output alu_en, alu_rd, alu_out, alu_ovf,
        output sfu_en, sfu_rd, sfu_out,
        output bru_en, bru_rd, bru_addr, bru_pre_right, bru_b_type, bru_real_dir,
        output agu_en, agu_rd, agu_out,
        input  alu_ready, sfu_ready, bru_ready, agu_ready,
        input  cdb_valid, cdb_tag, cdb_data, cdb_src, cdb_exc, cdb_b_type, cdb_real_dir,
        input  redirect_valid, redirect_addr
    );

    modport slave (
        input  flush,
        input  alu_en, alu_rd, alu_out, alu_ovf,
        input  sfu_en, sfu_rd, sfu_out,
        input  bru_en, bru_rd, bru_addr, bru_pre_right, bru_b_type, bru_real_dir,
        input  agu_en, agu_rd, agu_out,
        output alu_ready, sfu_ready, bru_ready, agu_ready,
        output cdb_valid, cdb_tag, cdb_data, cdb_src, cdb_exc, cdb_b_type, cdb_real_dir,
        output redirect_valid, redirect_addr
    );
endinterface

// File: rtl/wb_result_bus.sv
// Writeback collector: four per-unit result queues, round-robin onto one registered CDB,
// registered mispredict redirect. Define WB_OVF_TRAP_EN to carry ALU overflow to cdb_exc.
module wb_result_bus #(
    parameter int unsigned DEPTH = 2
) (
    input logic            clk,
    input logic            rst,
    wb_result_bus_if.slave bus
);
    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = $clog2(DEPTH + 1);
    localparam int unsigned NumQ = 4;

    localparam logic [1:0] SrcAlu = 2'd0;
    localparam logic [1:0] SrcSfu = 2'd1;
    localparam logic [1:0] SrcBru = 2'd2;
    localparam logic [1:0] SrcAgu = 2'd3;

    // Queue storage, indexed by source unit
    logic [5:0]  tag_mem  [NumQ][DEPTH];
    logic [31:0] data_mem [NumQ][DEPTH];
    logic        bru_pre_right_mem [DEPTH];
    logic        bru_b_type_mem    [DEPTH];
    logic        bru_real_dir_mem  [DEPTH];
`ifdef WB_OVF_TRAP_EN
    logic        alu_ovf_mem [DEPTH];
`endif

    logic [NumQ-1:0][PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [NumQ-1:0][PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [NumQ-1:0][CntW-1:0] count_q, count_d;
    logic [1:0]                rr_ptr_q, rr_ptr_d;

    logic [NumQ-1:0]           in_en;
    logic [NumQ-1:0][5:0]      in_tag;
    logic [NumQ-1:0][31:0]     in_data;
    logic [NumQ-1:0]           ready;
    logic [NumQ-1:0]           push;
    logic [NumQ-1:0]           nonempty;
    logic [NumQ-1:0]           pop;

    logic       grant_valid;
    logic [1:0] grant_idx;
    logic [1:0] cand;
    logic [5:0] head_tag;
    logic [31:0] head_data;
    logic       head_exc;
    logic       head_b_type;
    logic       head_real_dir;
    logic       head_mispred;

    logic        cdb_valid_q, cdb_valid_d;
    logic [5:0]  cdb_tag_q, cdb_tag_d;
    logic [31:0] cdb_data_q, cdb_data_d;
    logic [1:0]  cdb_src_q, cdb_src_d;
    logic        cdb_exc_q, cdb_exc_d;
    logic        cdb_b_type_q, cdb_b_type_d;
    logic        cdb_real_dir_q, cdb_real_dir_d;
    logic        redirect_valid_q, redirect_valid_d;
    logic [31:0] redirect_addr_q, redirect_addr_d;

`ifndef WB_OVF_TRAP_EN
    logic unused_alu_ovf;
    assign unused_alu_ovf = bus.alu_ovf;
`endif

    always_comb begin
        in_en   = {bus.agu_en, bus.bru_en, bus.sfu_en, bus.alu_en};
        in_tag  = {bus.agu_rd, bus.bru_rd, bus.sfu_rd, bus.alu_rd};
        in_data = {bus.agu_out, bus.bru_addr, bus.sfu_out, bus.alu_out};
        for (int i = 0; i < NumQ; i++) begin
            // No pop-to-push bypass: a full queue stays not-ready even while draining
            ready[i]    = (count_q[i] != CntW'(DEPTH));
            nonempty[i] = (count_q[i] != '0);
            push[i]     = in_en[i] & ready[i] & ~bus.flush;
        end
    end

    // Round-robin scan starting at rr_ptr; flush suppresses any grant
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = rr_ptr_q;
        cand        = rr_ptr_q;
        for (int i = 0; i < NumQ; i++) begin
            cand = rr_ptr_q + 2'(i);
            if (!grant_valid && nonempty[cand] && !bus.flush) begin
                grant_valid = 1'b1;
                grant_idx   = cand;
            end
        end
        pop = '0;
        pop[grant_idx] = grant_valid;
    end

    always_comb begin
        head_tag      = tag_mem[grant_idx][rd_ptr_q[grant_idx]];
        head_data     = data_mem[grant_idx][rd_ptr_q[grant_idx]];
        head_b_type   = 1'b0;
        head_real_dir = 1'b0;
        head_mispred  = 1'b0;
        head_exc      = 1'b0;
        if (grant_idx == SrcBru) begin
            head_b_type   = bru_b_type_mem[rd_ptr_q[SrcBru]];
            head_real_dir = bru_real_dir_mem[rd_ptr_q[SrcBru]];
            head_mispred  = ~bru_pre_right_mem[rd_ptr_q[SrcBru]];
        end
`ifdef WB_OVF_TRAP_EN
        if (grant_idx == SrcAlu) begin
            head_exc = alu_ovf_mem[rd_ptr_q[SrcAlu]];
        end
`endif
    end

    always_comb begin
        for (int i = 0; i < NumQ; i++) begin
            wr_ptr_d[i] = wr_ptr_q[i] + PtrW'(push[i]);
            rd_ptr_d[i] = rd_ptr_q[i] + PtrW'(pop[i]);
            count_d[i]  = count_q[i] + CntW'(push[i]) - CntW'(pop[i]);
            if (bus.flush) begin
                wr_ptr_d[i] = '0;
                rd_ptr_d[i] = '0;
                count_d[i]  = '0;
            end
        end
        rr_ptr_d = grant_valid ? grant_idx + 2'd1 : rr_ptr_q;

        cdb_valid_d    = grant_valid;
        cdb_tag_d      = cdb_tag_q;
        cdb_data_d     = cdb_data_q;
        cdb_src_d      = cdb_src_q;
        cdb_exc_d      = cdb_exc_q;
        cdb_b_type_d   = cdb_b_type_q;
        cdb_real_dir_d = cdb_real_dir_q;
        if (grant_valid) begin
            cdb_tag_d      = head_tag;
            cdb_data_d     = head_data;
            cdb_src_d      = grant_idx;
            cdb_exc_d      = head_exc;
            cdb_b_type_d   = head_b_type;
            cdb_real_dir_d = head_real_dir;
        end

        redirect_valid_d = grant_valid & head_mispred;
        redirect_addr_d  = (grant_valid && head_mispred) ? head_data : redirect_addr_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q         <= '0;
            rd_ptr_q         <= '0;
            count_q          <= '0;
            rr_ptr_q         <= 2'd0;
            cdb_valid_q      <= 1'b0;
            cdb_tag_q        <= '0;
            cdb_data_q       <= '0;
            cdb_src_q        <= SrcAlu;
            cdb_exc_q        <= 1'b0;
            cdb_b_type_q     <= 1'b0;
            cdb_real_dir_q   <= 1'b0;
            redirect_valid_q <= 1'b0;
            redirect_addr_q  <= '0;
        end else begin
            wr_ptr_q         <= wr_ptr_d;
            rd_ptr_q         <= rd_ptr_d;
            count_q          <= count_d;
            rr_ptr_q         <= rr_ptr_d;
            cdb_valid_q      <= cdb_valid_d;
            cdb_tag_q        <= cdb_tag_d;
            cdb_data_q       <= cdb_data_d;
            cdb_src_q        <= cdb_src_d;
            cdb_exc_q        <= cdb_exc_d;
            cdb_b_type_q     <= cdb_b_type_d;
            cdb_real_dir_q   <= cdb_real_dir_d;
            redirect_valid_q <= redirect_valid_d;
            redirect_addr_q  <= redirect_addr_d;
        end
    end

    // Payload storage needs no reset: only entries below count are ever read
    always_ff @(posedge clk) begin
        for (int i = 0; i < NumQ; i++) begin
            if (push[i] && !rst) begin
                tag_mem[i][wr_ptr_q[i]]  <= in_tag[i];
                data_mem[i][wr_ptr_q[i]] <= in_data[i];
            end
        end
        if (push[SrcBru] && !rst) begin
            bru_pre_right_mem[wr_ptr_q[SrcBru]] <= bus.bru_pre_right;
            bru_b_type_mem[wr_ptr_q[SrcBru]]    <= bus.bru_b_type;
            bru_real_dir_mem[wr_ptr_q[SrcBru]]  <= bus.bru_real_dir;
        end
`ifdef WB_OVF_TRAP_EN
        if (push[SrcAlu] && !rst) begin
            alu_ovf_mem[wr_ptr_q[SrcAlu]] <= bus.alu_ovf;
        end
`endif
    end

    assign bus.alu_ready      = ready[SrcAlu];
    assign bus.sfu_ready      = ready[SrcSfu];
    assign bus.bru_ready      = ready[SrcBru];
    assign bus.agu_ready      = ready[SrcAgu];
    assign bus.cdb_valid      = cdb_valid_q;
    assign bus.cdb_tag        = cdb_tag_q;
    assign bus.cdb_data       = cdb_data_q;
    assign bus.cdb_src        = cdb_src_q;
    assign bus.cdb_exc        = cdb_exc_q;
    assign bus.cdb_b_type     = cdb_b_type_q;
    assign bus.cdb_real_dir   = cdb_real_dir_q;
    assign bus.redirect_valid = redirect_valid_q;
    assign bus.redirect_addr  = redirect_addr_q;
endmodule

// File: tb/tb_wb_result_bus.sv
// Scoreboard bench for wb_result_bus: stimulus queues expected CDB results, a negedge
// monitor pops and compares every broadcast. Honours WB_OVF_TRAP_EN for cdb_exc.
module tb_wb_result_bus;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    wb_result_bus_if bus ();

    wb_result_bus #(.DEPTH(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

`ifdef WB_OVF_TRAP_EN
    localparam logic OvfTrap = 1'b1;
`else
    localparam logic OvfTrap = 1'b0;
`endif

    typedef struct {
        logic [5:0]  tag;
        logic [31:0] data;
        logic [1:0]  src;
        logic        exc;
        logic        b_type;
        logic        real_dir;
        logic        redir;
    } exp_t;

    exp_t exp_q [$];
    int tests  = 0;
    int failed = 0;

    task automatic push_exp(input logic [5:0] tag, input logic [31:0] data, input logic [1:0] src,
                            input logic exc, input logic b_type, input logic real_dir,
                            input logic redir);
        exp_t e;
        e.tag = tag; e.data = data; e.src = src; e.exc = exc;
        e.b_type = b_type; e.real_dir = real_dir; e.redir = redir;
        exp_q.push_back(e);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            failed++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.flush = 1'b0;
        bus.alu_en = 1'b0; bus.alu_rd = '0; bus.alu_out = '0; bus.alu_ovf = 1'b0;
        bus.sfu_en = 1'b0; bus.sfu_rd = '0; bus.sfu_out = '0;
        bus.bru_en = 1'b0; bus.bru_rd = '0; bus.bru_addr = '0;
        bus.bru_pre_right = 1'b1; bus.bru_b_type = 1'b0; bus.bru_real_dir = 1'b0;
        bus.agu_en = 1'b0; bus.agu_rd = '0; bus.agu_out = '0;
    endtask

    function automatic logic [5:0] unit_tag(input int u, input int k);
        return 6'(u * 16 + k);
    endfunction

    function automatic logic [31:0] unit_data(input int u, input int k);
        return 32'hA000_0000 + 32'(u * 256 + k);
    endfunction

    task automatic drive_unit(input int u, input int k, input logic en);
        logic kb;
        kb = 1'(k & 1);
        case (u)
            0: begin
                bus.alu_en = en; bus.alu_rd = unit_tag(u, k); bus.alu_out = unit_data(u, k);
                bus.alu_ovf = 1'b0;
            end
            1: begin
                bus.sfu_en = en; bus.sfu_rd = unit_tag(u, k); bus.sfu_out = unit_data(u, k);
            end
            2: begin
                bus.bru_en = en; bus.bru_rd = unit_tag(u, k); bus.bru_addr = unit_data(u, k);
                bus.bru_pre_right = 1'b1; bus.bru_b_type = kb; bus.bru_real_dir = ~kb;
            end
            default: begin
                bus.agu_en = en; bus.agu_rd = unit_tag(u, k); bus.agu_out = unit_data(u, k);
            end
        endcase
    endtask

    function automatic logic unit_ready(input int u);
        case (u)
            0:       return bus.alu_ready;
            1:       return bus.sfu_ready;
            2:       return bus.bru_ready;
            default: return bus.agu_ready;
        endcase
    endfunction

    task automatic wait_drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 40) begin
            tick();
            n++;
        end
        repeat (3) tick();
        tests++;
        if (exp_q.size() != 0) begin
            failed++;
            $display("FAIL drain: %0d results still pending, required 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_cdb_valid"}, 32'(bus.cdb_valid), 32'd0);
        check({tag, "_cdb_tag"}, 32'(bus.cdb_tag), 32'd0);
        check({tag, "_cdb_data"}, bus.cdb_data, 32'd0);
        check({tag, "_cdb_src"}, 32'(bus.cdb_src), 32'd0);
        check({tag, "_cdb_exc"}, 32'(bus.cdb_exc), 32'd0);
        check({tag, "_cdb_b_type"}, 32'(bus.cdb_b_type), 32'd0);
        check({tag, "_cdb_real_dir"}, 32'(bus.cdb_real_dir), 32'd0);
        check({tag, "_redirect_valid"}, 32'(bus.redirect_valid), 32'd0);
        check({tag, "_redirect_addr"}, bus.redirect_addr, 32'd0);
        check({tag, "_readies"}, 32'({bus.agu_ready, bus.bru_ready, bus.sfu_ready, bus.alu_ready}),
              32'hf);
    endtask

    // Monitor: every broadcast must match the head of the scoreboard
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (bus.cdb_valid === 1'b1) begin
                tests++;
                if (exp_q.size() == 0) begin
                    failed++;
                    $display("FAIL cdb_unexpected: got tag=%0d src=%0d, required no broadcast",
                             bus.cdb_tag, bus.cdb_src);
                end else begin
                    e = exp_q.pop_front();
                    if (bus.cdb_tag !== e.tag || bus.cdb_data !== e.data || bus.cdb_src !== e.src
                        || bus.cdb_exc !== e.exc || bus.cdb_b_type !== e.b_type
                        || bus.cdb_real_dir !== e.real_dir || bus.redirect_valid !== e.redir
                        || (e.redir && bus.redirect_addr !== e.data)) begin
                        failed++;
                        $display({"FAIL cdb_result: got tag=%0d data=0x%0h src=%0d exc=%0b ",
                                  "bt=%0b dir=%0b redir=%0b addr=0x%0h, required tag=%0d ",
                                  "data=0x%0h src=%0d exc=%0b bt=%0b dir=%0b redir=%0b"},
                                 bus.cdb_tag, bus.cdb_data, bus.cdb_src, bus.cdb_exc,
                                 bus.cdb_b_type, bus.cdb_real_dir, bus.redirect_valid,
                                 bus.redirect_addr, e.tag, e.data, e.src, e.exc, e.b_type,
                                 e.real_dir, e.redir);
                    end
                end
            end else if (bus.redirect_valid !== 1'b0) begin
                tests++;
                failed++;
                $display("FAIL redirect_idle: got redirect_valid=%0b, required 0",
                         bus.redirect_valid);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, required finish");
        $fatal(1, "timeout");
    end

    initial begin
        int  idx [4];
        logic acc [4];
        bit  done;

        clear_inputs();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check_reset_state("reset");

        // All four units push back-to-back from reset: strict ALU,SFU,BRU,AGU rotation
        for (int k = 0; k < 3; k++) begin
            for (int u = 0; u < 4; u++) begin
                push_exp(unit_tag(u, k), unit_data(u, k), 2'(u), 1'b0,
                         (u == 2) ? 1'(k & 1) : 1'b0, (u == 2) ? ~1'(k & 1) : 1'b0, 1'b0);
            end
        end
        for (int u = 0; u < 4; u++) idx[u] = 0;
        for (int c = 0; c < 20; c++) begin
            done = 1'b1;
            for (int u = 0; u < 4; u++) if (idx[u] < 3) done = 1'b0;
            if (done) break;
            for (int u = 0; u < 4; u++) drive_unit(u, idx[u], idx[u] < 3);
            @(negedge clk);
            for (int u = 0; u < 4; u++) acc[u] = (idx[u] < 3) && unit_ready(u);
            if (c == 2) begin
                check("rot_alu_ready", 32'(bus.alu_ready), 32'd1);
                check("rot_sfu_full", 32'(bus.sfu_ready), 32'd0);
                check("rot_agu_full", 32'(bus.agu_ready), 32'd0);
            end
            tick();
            for (int u = 0; u < 4; u++) if (acc[u]) idx[u]++;
        end
        clear_inputs();
        wait_drain();

        // Single ALU result: visible after the second edge, not the first
        bus.alu_en = 1'b1; bus.alu_rd = 6'd5; bus.alu_out = 32'h1234;
        push_exp(6'd5, 32'h1234, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        clear_inputs();
        check("latency_min", 32'(bus.cdb_valid), 32'd0);
        wait_drain();

        // rr_ptr now 1: SFU wins the first grant, ALU fills, then flush with AGU pushing
        bus.alu_en = 1'b1; bus.alu_rd = 6'h30; bus.alu_out = 32'h300;
        bus.sfu_en = 1'b1; bus.sfu_rd = 6'h31; bus.sfu_out = 32'h310;
        push_exp(6'h31, 32'h310, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        bus.sfu_en = 1'b0; bus.alu_rd = 6'h32; bus.alu_out = 32'h320;
        tick();
        check("fill_alu_ready", 32'(bus.alu_ready), 32'd0);
        bus.flush = 1'b1;
        bus.alu_rd = 6'h33; bus.alu_out = 32'h330;
        bus.agu_en = 1'b1; bus.agu_rd = 6'h34; bus.agu_out = 32'h340;
        tick();
        clear_inputs();
        check("flush_cdb_valid", 32'(bus.cdb_valid), 32'd0);
        check("flush_redirect", 32'(bus.redirect_valid), 32'd0);
        check("flush_readies", 32'({bus.agu_ready, bus.bru_ready, bus.sfu_ready, bus.alu_ready}),
              32'hf);
        repeat (4) tick();
        wait_drain();

        // Mispredicted branch then correctly predicted branch
        bus.bru_en = 1'b1; bus.bru_rd = 6'd9; bus.bru_addr = 32'h80;
        bus.bru_pre_right = 1'b0; bus.bru_b_type = 1'b1; bus.bru_real_dir = 1'b1;
        push_exp(6'd9, 32'h80, 2'd2, 1'b0, 1'b1, 1'b1, 1'b1);
        tick();
        clear_inputs();
        wait_drain();
        bus.bru_en = 1'b1; bus.bru_rd = 6'd10; bus.bru_addr = 32'h90;
        bus.bru_pre_right = 1'b1; bus.bru_b_type = 1'b1; bus.bru_real_dir = 1'b0;
        push_exp(6'd10, 32'h90, 2'd2, 1'b0, 1'b1, 1'b0, 1'b0);
        tick();
        clear_inputs();
        wait_drain();
        check("redirect_addr_hold", bus.redirect_addr, 32'h80);

        // ALU overflow
        bus.alu_en = 1'b1; bus.alu_rd = 6'd7; bus.alu_out = 32'h77; bus.alu_ovf = 1'b1;
        push_exp(6'd7, 32'h77, 2'd0, OvfTrap, 1'b0, 1'b0, 1'b0);
        tick();
        clear_inputs();
        wait_drain();

        // Reset with all queues occupied (rr_ptr is 1 here); afterwards ALU must win first
        for (int u = 0; u < 4; u++) drive_unit(u, 8, 1'b1);
        tick();
        clear_inputs();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_reset_state("midrst");
        bus.alu_en = 1'b1; bus.alu_rd = 6'h21; bus.alu_out = 32'h21;
        bus.sfu_en = 1'b1; bus.sfu_rd = 6'h22; bus.sfu_out = 32'h22;
        push_exp(6'h21, 32'h21, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        push_exp(6'h22, 32'h22, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        clear_inputs();
        wait_drain();

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
